// File: rtl/l1d_pkg.sv
// rtl/l1d_pkg.sv - shared types, default sizes and address-split helpers for the L1 data cache
//
// Contents:
//   l1d_state_t      controller state encoding
//   L1D_* constants  default geometry used by l1d_cache_wt and l1d_victim_sel
//   l1d_*_w()        field widths of the word address tag|index|offset and of a way index

package l1d_pkg;

    localparam int L1D_ADDR_W         = 32;
    localparam int L1D_DATA_W         = 32;
    localparam int L1D_WAYS           = 4;
    localparam int L1D_SETS           = 16;
    localparam int L1D_WORDS_PER_LINE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_RD,
        ST_REFILL,
        ST_MEM_WR,
        ST_RESP
    } l1d_state_t;

    function automatic int l1d_off_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int l1d_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int l1d_tag_w(input int addr_w, input int sets, input int words_per_line);
        return addr_w - l1d_idx_w(sets) - l1d_off_w(words_per_line);
    endfunction

    // A direct-mapped cache still carries a 1-bit way index / FIFO pointer.
    function automatic int l1d_way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/l1d_victim_sel.sv
// rtl/l1d_victim_sel.sv - combinational refill victim choice for one set
//
// Ports:
//   valid_vec  in   WAYS   valid bits of the addressed set
//   fifo_ptr   in   WAY_W  FIFO replacement pointer of the addressed set
//   victim     out  WAY_W  lowest-index invalid way, else fifo_ptr

module l1d_victim_sel
    import l1d_pkg::*;
#(
    parameter int WAYS  = L1D_WAYS,
    parameter int WAY_W = l1d_way_w(WAYS)
) (
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAY_W-1:0] fifo_ptr,
    output logic [WAY_W-1:0] victim
);

    // Walk from the top down so the lowest invalid way is the last one to win.
    always_comb begin
        victim = fifo_ptr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_vec[w]) begin
                victim = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/l1d_cache_wt.sv
// rtl/l1d_cache_wt.sv - set-associative write-through, no-write-allocate L1 data cache
//
// Optional feature macro: L1D_STATS_EN (adds saturating stat_hits / stat_misses counters).
//
// Ports:
//   CLK, RESET_N                     clock (rising edge), asynchronous active-low reset
//   cpu_req_valid/ready/we/addr/wdata CPU request, accepted only in IDLE
//   cpu_resp_valid/rdata             one-cycle response; rdata is 0 for stores
//   mem_req_valid/ready/we/addr/wdata memory request: line read (aligned) or word write (exact)
//   mem_rdata_valid/mem_rdata        refill beats in ascending word order
//   stat_hits/stat_misses            lookup hit/miss counters (L1D_STATS_EN only)

module l1d_cache_wt
    import l1d_pkg::*;
#(
    parameter int ADDR_W         = L1D_ADDR_W,
    parameter int DATA_W         = L1D_DATA_W,
    parameter int WAYS           = L1D_WAYS,
    parameter int SETS           = L1D_SETS,
    parameter int WORDS_PER_LINE = L1D_WORDS_PER_LINE
) (
    input  logic              CLK,
    input  logic              RESET_N,
`ifdef L1D_STATS_EN
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
`endif
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF_W = l1d_off_w(WORDS_PER_LINE);
    localparam int IDX_W = l1d_idx_w(SETS);
    localparam int TAG_W = l1d_tag_w(ADDR_W, SETS, WORDS_PER_LINE);
    localparam int WAY_W = l1d_way_w(WAYS);

    l1d_state_t        state_q, state_d;
    logic              req_we_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic [OFF_W-1:0]  beat_q;

    logic [WAYS-1:0]   valid_q    [SETS];
    logic [WAY_W-1:0]  fifo_ptr_q [SETS];
    logic [TAG_W-1:0]  tag_q      [SETS][WAYS];
    logic [DATA_W-1:0] data_q     [SETS][WAYS][WORDS_PER_LINE];
    logic [DATA_W-1:0] line_buf_q [WORDS_PER_LINE];
    logic [DATA_W-1:0] resp_data_q;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [DATA_W-1:0] hit_word;
    logic [WAY_W-1:0]  victim_way;
    logic              beat_take;
    logic              fill;

    assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx  = req_addr_q[OFF_W +: IDX_W];
    assign req_off  = req_addr_q[OFF_W-1:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_word = data_q[req_idx][hit_way][req_off];

    l1d_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid_vec (valid_q[req_idx]),
        .fifo_ptr  (fifo_ptr_q[req_idx]),
        .victim    (victim_way)
    );

    // Beats are only meaningful while refilling; stray valids elsewhere are dropped.
    assign beat_take = (state_q == ST_REFILL) && mem_rdata_valid;
    assign fill      = beat_take && (beat_q == OFF_W'(WORDS_PER_LINE - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cpu_req_valid) state_d = ST_LOOKUP;
            ST_LOOKUP: begin
                if (req_we_q)  state_d = ST_MEM_WR;
                else if (hit)  state_d = ST_RESP;
                else           state_d = ST_MEM_RD;
            end
            ST_MEM_RD: if (mem_req_ready) state_d = ST_REFILL;
            ST_REFILL: if (fill)          state_d = ST_RESP;
            ST_MEM_WR: if (mem_req_ready) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            beat_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s]    <= '0;
                fifo_ptr_q[s] <= '0;
            end
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && cpu_req_valid) begin
                req_we_q    <= cpu_req_we;
                req_addr_q  <= cpu_req_addr;
                req_wdata_q <= cpu_req_wdata;
            end
            if (state_q == ST_MEM_RD) begin
                beat_q <= '0;
            end else if (beat_take) begin
                beat_q <= beat_q + 1'b1;
            end
            if (fill) begin
                valid_q[req_idx][victim_way] <= 1'b1;
                fifo_ptr_q[req_idx] <= (fifo_ptr_q[req_idx] == WAY_W'(WAYS - 1))
                                       ? '0 : fifo_ptr_q[req_idx] + 1'b1;
            end
        end
    end

    // Arrays carry no reset: validity lives in valid_q, and an abandoned refill
    // never reaches the array because the async reset forces IDLE first.
    always_ff @(posedge CLK) begin
        if (beat_take) begin
            line_buf_q[beat_q] <= mem_rdata;
            if (beat_q == req_off) begin
                resp_data_q <= mem_rdata;
            end
        end
        if ((state_q == ST_LOOKUP) && hit) begin
            if (req_we_q) begin
                data_q[req_idx][hit_way][req_off] <= req_wdata_q;
            end else begin
                resp_data_q <= hit_word;
            end
        end
        if (fill) begin
            tag_q[req_idx][victim_way] <= req_tag;
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                data_q[req_idx][victim_way][w] <= (w == WORDS_PER_LINE - 1) ? mem_rdata : line_buf_q[w];
            end
        end
    end

`ifdef L1D_STATS_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit) begin
                if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
            end else begin
                if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

    assign cpu_req_ready  = (state_q == ST_IDLE);
    assign cpu_resp_valid = (state_q == ST_RESP);
    assign cpu_resp_rdata = ((state_q == ST_RESP) && !req_we_q) ? resp_data_q : '0;
    assign mem_req_valid  = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    assign mem_req_we     = (state_q == ST_MEM_WR);
    assign mem_req_addr   = (state_q == ST_MEM_RD) ? {req_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} :
                            (state_q == ST_MEM_WR) ? req_addr_q : '0;
    assign mem_req_wdata  = (state_q == ST_MEM_WR) ? req_wdata_q : '0;

endmodule

// File: tb/tb_l1d_cache_wt.sv
// tb/tb_l1d_cache_wt.sv - self-checking bench for l1d_cache_wt with a FIFO-set cache model

module tb_l1d_cache_wt;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_we = 1'b0;
    logic [31:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef L1D_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    l1d_cache_wt dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
`ifdef L1D_STATS_EN
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses),
`endif
        .cpu_req_valid   (cpu_req_valid),
        .cpu_req_ready   (cpu_req_ready),
        .cpu_req_we      (cpu_req_we),
        .cpu_req_addr    (cpu_req_addr),
        .cpu_req_wdata   (cpu_req_wdata),
        .cpu_resp_valid  (cpu_resp_valid),
        .cpu_resp_rdata  (cpu_resp_rdata),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_we      (mem_req_we),
        .mem_req_addr    (mem_req_addr),
        .mem_req_wdata   (mem_req_wdata),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_checks = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endfunction

    // Model: external memory is a sparse word store; each set is a FIFO of resident line addresses.
    logic [31:0] mem_w [logic [31:0]];
    logic [31:0] cset [16][$];
    int          m_hits = 0;
    int          m_misses = 0;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (mem_w.exists(a)) return mem_w[a];
        return a + 32'h60;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 16; s++) cset[s].delete();
        m_hits = 0;
        m_misses = 0;
    endfunction

    // 0 = no memory request, 1 = line read, 2 = word write
    int          exp_mem_kind = 0;
    logic [31:0] exp_mem_addr = '0;
    logic [31:0] exp_mem_wdata = '0;
    logic [31:0] exp_rdata = '0;
    int          exp_lat = 0;
    bit          pending = 0;
    int          cyc = 0;
    int          accept_cyc = 0;
    int          mem_starts = 0;
    bit          mem_prev = 0;
    logic [31:0] last_rdata = '0;
    logic [31:0] last_mem_addr = '0;
    logic [31:0] last_mem_wdata = '0;
    int          last_lat = 0;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (RESET_N) begin
            if (mem_req_valid) begin
                if (!mem_prev) begin
                    mem_starts++;
                    last_mem_addr  = mem_req_addr;
                    last_mem_wdata = mem_req_wdata;
                    chk("mem_req_expected", 32'(exp_mem_kind != 0), 32'd1);
                end
                chk("mem_req_we", 32'(mem_req_we), 32'(exp_mem_kind == 2));
                chk("mem_req_addr", mem_req_addr, exp_mem_addr);
                if (exp_mem_kind == 2) chk("mem_req_wdata", mem_req_wdata, exp_mem_wdata);
            end
            mem_prev = mem_req_valid;
            if (cpu_resp_valid) begin
                chk("resp_expected", 32'(pending), 32'd1);
                if (pending) begin
                    last_rdata = cpu_resp_rdata;
                    last_lat   = cyc - accept_cyc + 1;
                    chk("resp_rdata", cpu_resp_rdata, exp_rdata);
                    chk("resp_latency", 32'(last_lat), 32'(exp_lat));
                    pending = 0;
                end
            end
        end else begin
            mem_prev = 0;
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        cpu_req_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rdata_valid = 1'b0;
        pending = 0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
    endtask

    task automatic req(input bit we, input logic [31:0] addr, input logic [31:0] wd, input int stall);
        logic [31:0] line;
        int          s;
        bit          hit;
        int          st0;
        int          k;
        line = addr & ~32'h7;
        s    = int'(addr[6:3]);
        hit  = 0;
        for (int i = 0; i < cset[s].size(); i++) if (cset[s][i] == line) hit = 1;
        if (hit) m_hits++; else m_misses++;
        if (we) begin
            mem_w[addr]   = wd;
            exp_mem_kind  = 2;
            exp_mem_addr  = addr;
            exp_mem_wdata = wd;
            exp_rdata     = '0;
            exp_lat       = 3 + stall;
        end else if (hit) begin
            exp_mem_kind = 0;
            exp_rdata    = memval(addr);
            exp_lat      = 2;
        end else begin
            exp_mem_kind = 1;
            exp_mem_addr = line;
            exp_rdata    = memval(addr);
            exp_lat      = 11 + stall;
            if (cset[s].size() == 4) void'(cset[s].pop_front());
            cset[s].push_back(line);
        end
        st0 = mem_starts;
        @(negedge CLK);
        chk("req_ready_idle", 32'(cpu_req_ready), 32'd1);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        @(negedge CLK);
        accept_cyc    = cyc;
        pending       = 1;
        cpu_req_valid = 1'b0;
        chk("req_ready_drop", 32'(cpu_req_ready), 32'd0);
        if (exp_mem_kind != 0) begin
            k = 0;
            while (!mem_req_valid && k < 20) begin
                @(negedge CLK);
                k++;
            end
            if (!mem_req_valid) begin
                chk("mem_req_timeout", 32'd0, 32'd1);
            end else begin
                // Stray beats while the read is still waiting must be ignored.
                repeat (stall) begin
                    if (exp_mem_kind == 1) begin
                        mem_rdata_valid = 1'b1;
                        mem_rdata = 32'hBAD0BAD0;
                    end
                    @(negedge CLK);
                end
                mem_rdata_valid = 1'b0;
                mem_req_ready = 1'b1;
                @(negedge CLK);
                mem_req_ready = 1'b0;
                if (exp_mem_kind == 1) begin
                    for (int b = 0; b < 8; b++) begin
                        mem_rdata_valid = 1'b1;
                        mem_rdata = memval(line + 32'(b));
                        @(negedge CLK);
                    end
                    mem_rdata_valid = 1'b0;
                    mem_rdata = '0;
                end
            end
        end
        k = 0;
        while (pending && k < 40) begin
            @(negedge CLK);
            k++;
        end
        if (pending) begin
            chk("resp_timeout", 32'd0, 32'd1);
            pending = 0;
        end
        chk("mem_req_count", 32'(mem_starts - st0), 32'(exp_mem_kind != 0));
    endtask

    initial begin
        int k;
        int r0;
        #1;
        chk("rst_ready", 32'(cpu_req_ready), 32'd1);
        chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_addr", mem_req_addr, 32'd0);
        do_reset();
        @(negedge CLK);
        chk("post_rst_ready", 32'(cpu_req_ready), 32'd1);
        chk("post_rst_rdata", cpu_resp_rdata, 32'd0);

        // Cold load miss then hit in the same line
        req(0, 32'h43, 0, 0);
        chk("t1_rdata", last_rdata, 32'hA3);
        chk("t1_mem_addr", last_mem_addr, 32'h40);
        chk("t1_lat", 32'(last_lat), 32'd11);
        req(0, 32'h45, 0, 0);
        chk("t1_hit_rdata", last_rdata, 32'hA5);
        chk("t1_hit_lat", 32'(last_lat), 32'd2);

        // Store hit is written through and updates the cached line
        req(1, 32'h43, 32'hDEADBEEF, 0);
        chk("t2_wr_addr", last_mem_addr, 32'h43);
        chk("t2_wr_data", last_mem_wdata, 32'hDEADBEEF);
        req(0, 32'h43, 0, 0);
        chk("t2_rdata", last_rdata, 32'hDEADBEEF);
        chk("t2_lat", 32'(last_lat), 32'd2);

        // Store miss does not allocate; memory held off 5 cycles
        req(1, 32'h1000, 32'h11, 5);
        chk("t3_wr_lat", 32'(last_lat), 32'd8);
        req(0, 32'h1000, 0, 5);
        chk("t3_rdata", last_rdata, 32'h11);
        chk("t3_lat", 32'(last_lat), 32'd16);

`ifdef L1D_STATS_EN
        chk("stat_hits", stat_hits, 32'(m_hits));
        chk("stat_misses", stat_misses, 32'(m_misses));
        chk("stat_hits_lit", stat_hits, 32'd3);
`endif

        // FIFO replacement in set 0
        do_reset();
`ifdef L1D_STATS_EN
        chk("stat_hits_rst", stat_hits, 32'd0);
        chk("stat_misses_rst", stat_misses, 32'd0);
`endif
        r0 = mem_starts;
        req(0, 32'h000, 0, 0);
        req(0, 32'h080, 0, 0);
        req(0, 32'h100, 0, 0);
        req(0, 32'h180, 0, 0);
        req(0, 32'h200, 0, 0);
        req(0, 32'h000, 0, 0);
        chk("t4_0x000_refetch_lat", 32'(last_lat), 32'd11);
        req(0, 32'h100, 0, 0);
        chk("t4_0x100_hit_lat", 32'(last_lat), 32'd2);
        req(0, 32'h080, 0, 0);
        chk("t4_0x080_miss_lat", 32'(last_lat), 32'd11);
        chk("t4_mem_reads", 32'(mem_starts - r0), 32'd7);

        // Reset in the middle of a refill abandons the line
        do_reset();
        exp_mem_kind = 1;
        exp_mem_addr = 32'h120;
        @(negedge CLK);
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 32'h123;
        @(negedge CLK);
        cpu_req_valid = 1'b0;
        k = 0;
        while (!mem_req_valid && k < 20) begin
            @(negedge CLK);
            k++;
        end
        chk("t5_mem_req_seen", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1'b1;
        @(negedge CLK);
        mem_req_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = memval(32'h120 + 32'(b));
            @(negedge CLK);
        end
        mem_rdata_valid = 1'b0;
        RESET_N = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(cpu_req_ready), 32'd1);
        chk("t5_rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        chk("t5_rst_rdata", cpu_resp_rdata, 32'd0);
        chk("t5_rst_mem_valid", 32'(mem_req_valid), 32'd0);
        chk("t5_rst_mem_we", 32'(mem_req_we), 32'd0);
        chk("t5_rst_mem_addr", mem_req_addr, 32'd0);
        chk("t5_rst_mem_wdata", mem_req_wdata, 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        req(0, 32'h123, 0, 0);
        chk("t5_reload_lat", 32'(last_lat), 32'd11);
        chk("t5_reload_rdata", last_rdata, 32'h183);

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
